if_stage: RTL and testbench

Instruction-fetch stage of the 5-stage RISC-V pipeline. Holds the program counter and drives the address input of the combinational `IMEM`. Captures the returned instruction into the IF/ID pipeline register for the decode stage. Handles hazard-unit stalls, taken-branch/jump redirects from EX (with flush of the wrong-path instruction), and misaligned redirect targets.

---
 rtl/if_stage.sv | 108 ++++++++++
 tb/tb_if_stage.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, drives IMEM and loads
//               the IF/ID register, with stall, redirect/flush and
//               misaligned-target fault handling.
// Revision    : 1.0
// ============================================================================
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h00000000,
    parameter logic [31:0] NOP_INST = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_inst,
    output logic [31:0] id_pc,
    output logic [31:0] id_pc_plus4,
    output logic [31:0] id_inst,
    output logic        id_valid,
    output logic        misalign_fault,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q,          pc_d;
    logic [31:0] id_pc_q,       id_pc_d;
    logic [31:0] id_pc_plus4_q, id_pc_plus4_d;
    logic [31:0] id_inst_q,     id_inst_d;
    logic        id_valid_q,    id_valid_d;
    logic        fault_q,       fault_d;
    logic [31:0] fetch_count_q, fetch_count_d;

    logic [31:0] w_pc_plus4;
    logic        w_target_aligned;

    assign w_pc_plus4       = pc_q + 32'd4;
    assign w_target_aligned = (redirect_target[1:0] == 2'b00);

    // Next PC and sticky fault
    always_comb begin
        pc_d    = pc_q;
        fault_d = fault_q;
        if (fault_q) begin
            pc_d = pc_q;
        end else if (redirect_valid) begin
            if (w_target_aligned) begin
                pc_d = redirect_target;
            end else begin
                fault_d = 1'b1;
            end
        end else if (!stall) begin
            pc_d = w_pc_plus4;
        end
    end

    // IF/ID register: a redirect or an active fault always injects a bubble,
    // even when the hazard unit is stalling.
    always_comb begin
        id_pc_d       = id_pc_q;
        id_pc_plus4_d = id_pc_plus4_q;
        id_inst_d     = id_inst_q;
        id_valid_d    = id_valid_q;
        fetch_count_d = fetch_count_q;
        if (redirect_valid || fault_q) begin
            id_inst_d  = NOP_INST;
            id_valid_d = 1'b0;
        end else if (!stall) begin
            id_pc_d       = pc_q;
            id_pc_plus4_d = w_pc_plus4;
            id_inst_d     = imem_inst;
            id_valid_d    = 1'b1;
            fetch_count_d = fetch_count_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q          <= RESET_PC;
            id_pc_q       <= 32'd0;
            id_pc_plus4_q <= 32'd0;
            id_inst_q     <= NOP_INST;
            id_valid_q    <= 1'b0;
            fault_q       <= 1'b0;
            fetch_count_q <= 32'd0;
        end else begin
            pc_q          <= pc_d;
            id_pc_q       <= id_pc_d;
            id_pc_plus4_q <= id_pc_plus4_d;
            id_inst_q     <= id_inst_d;
            id_valid_q    <= id_valid_d;
            fault_q       <= fault_d;
            fetch_count_q <= fetch_count_d;
        end
    end

    assign imem_addr      = pc_q;
    assign id_pc          = id_pc_q;
    assign id_pc_plus4    = id_pc_plus4_q;
    assign id_inst        = id_inst_q;
    assign id_valid       = id_valid_q;
    assign misalign_fault = fault_q;
    assign fetch_count    = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Self-checking bench for if_stage: directed scenarios plus a
//               randomized run against a behavioural fetch model.
// Revision    : 1.0
// ============================================================================
module tb_if_stage;

    localparam logic [31:0] C_NOP = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst, stall, redirect_valid;
    logic [31:0] redirect_target;
    logic [31:0] imem_addr, imem_inst;
    logic [31:0] id_pc, id_pc_plus4, id_inst, fetch_count;
    logic        id_valid, misalign_fault;

    int checks = 0;
    int errors = 0;

    // Behavioural model state
    logic [31:0] m_pc, m_id_pc, m_id_pc4, m_inst, m_cnt;
    logic        m_valid, m_fault;

    if_stage dut (
        .clk             (clk),
        .rst             (rst),
        .stall           (stall),
        .redirect_valid  (redirect_valid),
        .redirect_target (redirect_target),
        .imem_addr       (imem_addr),
        .imem_inst       (imem_inst),
        .id_pc           (id_pc),
        .id_pc_plus4     (id_pc_plus4),
        .id_inst         (id_inst),
        .id_valid        (id_valid),
        .misalign_fault  (misalign_fault),
        .fetch_count     (fetch_count)
    );

    always #5 clk = ~clk;

    // Instruction memory content: a distinct word for every address
    function automatic logic [31:0] word_at(input logic [31:0] a);
        return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
    endfunction

    assign imem_inst = word_at(imem_addr);

    // One fetch-stage edge expressed from the stage's rules
    task automatic model_edge(input bit r, input bit s, input bit rv, input logic [31:0] rt);
        if (r) begin
            m_pc = 32'd0; m_id_pc = 32'd0; m_id_pc4 = 32'd0;
            m_inst = C_NOP; m_valid = 1'b0; m_fault = 1'b0; m_cnt = 32'd0;
        end else if (m_fault || rv) begin
            m_inst  = C_NOP;
            m_valid = 1'b0;
            if (!m_fault) begin
                if (rt % 4 == 0) m_pc = rt;
                else             m_fault = 1'b1;
            end
        end else if (!s) begin
            m_id_pc  = m_pc;
            m_id_pc4 = m_pc + 4;
            m_inst   = word_at(m_pc);
            m_valid  = 1'b1;
            m_cnt    = m_cnt + 1;
            m_pc     = m_pc + 4;
        end
    endtask

    // Drive inputs on the falling edge, clock once, settle past the edge
    task automatic step(input bit r, input bit s, input bit rv, input logic [31:0] rt);
        @(negedge clk);
        rst = r; stall = s; redirect_valid = rv; redirect_target = rt;
        @(posedge clk);
        model_edge(r, s, rv, rt);
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0);
        step(1, 1, 1, 32'h40);
        checks++;
        if (imem_addr !== 32'h0 || id_valid !== 1'b0 || id_inst !== C_NOP || id_pc !== 32'h0 ||
            id_pc_plus4 !== 32'h0 || misalign_fault !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL reset_state: addr=%h valid=%b inst=%h pc=%h pc4=%h fault=%b cnt=%0d, want 0/0/%h/0/0/0/0",
                     imem_addr, id_valid, id_inst, id_pc, id_pc_plus4, misalign_fault, fetch_count, C_NOP);
        end
    endtask

    task automatic test_sequential();
        step(1, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            step(0, 0, 0, 0);
            checks++;
            if (id_pc !== 32'(4 * i) || id_inst !== word_at(32'(4 * i)) || id_valid !== 1'b1) begin
                errors++;
                $display("FAIL seq_fetch[%0d]: pc=%h inst=%h valid=%b, want pc=%h inst=%h valid=1",
                         i, id_pc, id_inst, id_valid, 32'(4 * i), word_at(32'(4 * i)));
            end
        end
        checks++;
        if (fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL seq_count: got %0d want 5", fetch_count);
        end
    endtask

    task automatic test_stall();
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(0, 1, 0, 0);
            checks++;
            if (id_pc !== 32'd8 || imem_addr !== 32'd12 || fetch_count !== 32'd3) begin
                errors++;
                $display("FAIL stall_hold[%0d]: id_pc=%h addr=%h cnt=%0d, want 8/c/3",
                         i, id_pc, imem_addr, fetch_count);
            end
        end
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'd12 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_release1: id_pc=%h valid=%b, want c/1", id_pc, id_valid);
        end
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'd16 || fetch_count !== 32'd5) begin
            errors++;
            $display("FAIL stall_release2: id_pc=%h cnt=%0d, want 10/5", id_pc, fetch_count);
        end
    endtask

    task automatic test_redirect_stall();
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 32'h40);
        checks++;
        if (id_valid !== 1'b0 || id_inst !== C_NOP || imem_addr !== 32'h40 || id_pc !== 32'hC) begin
            errors++;
            $display("FAIL redir_flush: valid=%b inst=%h addr=%h id_pc=%h, want 0/%h/40/c",
                     id_valid, id_inst, imem_addr, id_pc, C_NOP);
        end
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'h40 || id_valid !== 1'b1 || id_inst !== word_at(32'h40)) begin
            errors++;
            $display("FAIL redir_target: id_pc=%h valid=%b inst=%h, want 40/1/%h",
                     id_pc, id_valid, id_inst, word_at(32'h40));
        end
    endtask

    task automatic test_misalign();
        step(1, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 0, 0);
        step(0, 0, 1, 32'h42);
        checks++;
        if (misalign_fault !== 1'b1 || imem_addr !== 32'h8 || id_valid !== 1'b0) begin
            errors++;
            $display("FAIL misalign_set: fault=%b addr=%h valid=%b, want 1/8/0",
                     misalign_fault, imem_addr, id_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(0, i[0], i[1], 32'h80);
            checks++;
            if (id_valid !== 1'b0 || imem_addr !== 32'h8 || misalign_fault !== 1'b1 || fetch_count !== 32'd2) begin
                errors++;
                $display("FAIL misalign_frozen[%0d]: valid=%b addr=%h fault=%b cnt=%0d, want 0/8/1/2",
                         i, id_valid, imem_addr, misalign_fault, fetch_count);
            end
        end
        step(1, 0, 0, 0);
        checks++;
        if (misalign_fault !== 1'b0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL misalign_clear: fault=%b addr=%h, want 0/0", misalign_fault, imem_addr);
        end
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'h0 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL misalign_restart: id_pc=%h valid=%b, want 0/1", id_pc, id_valid);
        end
    endtask

    task automatic test_wrap();
        step(0, 0, 1, 32'hFFFFFFFC);
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'hFFFFFFFC || id_pc_plus4 !== 32'h0 || imem_addr !== 32'h0) begin
            errors++;
            $display("FAIL wrap_last: id_pc=%h pc4=%h addr=%h, want fffffffc/0/0",
                     id_pc, id_pc_plus4, imem_addr);
        end
        step(0, 0, 0, 0);
        checks++;
        if (id_pc !== 32'h0 || id_pc_plus4 !== 32'h4 || id_valid !== 1'b1) begin
            errors++;
            $display("FAIL wrap_first: id_pc=%h pc4=%h valid=%b, want 0/4/1", id_pc, id_pc_plus4, id_valid);
        end
    endtask

    task automatic test_midrun_reset();
        step(1, 0, 0, 0);
        for (int i = 0; i < 7; i++) step(0, 0, 0, 0);
        checks++;
        if (fetch_count !== 32'd7) begin
            errors++;
            $display("FAIL midrun_pre: cnt=%0d want 7", fetch_count);
        end
        step(1, 1, 1, 32'h100);
        checks++;
        if (imem_addr !== 32'h0 || id_valid !== 1'b0 || fetch_count !== 32'h0) begin
            errors++;
            $display("FAIL midrun_reset: addr=%h valid=%b cnt=%0d, want 0/0/0", imem_addr, id_valid, fetch_count);
        end
    endtask

    task automatic test_random();
        bit          r, s, rv;
        logic [31:0] rt;
        step(1, 0, 0, 0);
        for (int i = 0; i < 600; i++) begin
            r  = ($urandom_range(0, 39) == 0);
            s  = ($urandom_range(0, 3) == 0);
            rv = ($urandom_range(0, 6) == 0);
            rt = $urandom & 32'hFFFF_FFFC;
            if ($urandom_range(0, 15) == 0) rt[1:0] = 2'($urandom_range(1, 3));
            step(r, s, rv, rt);
            checks++;
            if (imem_addr !== m_pc || id_pc !== m_id_pc || id_pc_plus4 !== m_id_pc4 ||
                id_inst !== m_inst || id_valid !== m_valid || misalign_fault !== m_fault ||
                fetch_count !== m_cnt) begin
                errors++;
                $display("FAIL random[%0d]: got addr=%h pc=%h pc4=%h inst=%h v=%b f=%b cnt=%0d want %h %h %h %h %b %b %0d",
                         i, imem_addr, id_pc, id_pc_plus4, id_inst, id_valid, misalign_fault, fetch_count,
                         m_pc, m_id_pc, m_id_pc4, m_inst, m_valid, m_fault, m_cnt);
            end
        end
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; redirect_valid = 1'b0; redirect_target = 32'h0;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_stall();
        test_misalign();
        test_wrap();
        test_midrun_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
